// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
// Holds the default divisor width, channel limit and index-width function.
package clk_div_pkg;

  localparam int W_DEFAULT = 8;
  localparam int NCH_MAX   = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, registered outputs.
// Ports: clk/rst_n, wr/wr_div write, sync align; clk_out, tick, pending.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int W           = W_DEFAULT,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  input  logic         sync,
  output logic         clk_out,
  output logic         tick,
  output logic         pending
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pdiv_q, pdiv_d;
  logic         pend_q, pend_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         bnd;
  logic         load;
  logic [W:0]   half;

  always_comb begin
    // div<=1 is a boundary on every edge; a stopped channel
    // therefore picks up a new divisor on the next edge.
    bnd    = (div_q <= W'(1)) || (cnt_q == div_q - W'(1));
    load   = sync || bnd;
    cnt_d  = cnt_q + W'(1);
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    if (load) begin
      cnt_d  = '0;
      pend_d = 1'b0;
      if (wr) begin
        div_d = wr_div;
      end else if (pend_q) begin
        div_d = pdiv_q;
      end
    end else if (wr) begin
      pdiv_d = wr_div;
      pend_d = 1'b1;
    end
    // Outputs follow next state so the flops carry the
    // waveform itself; odd divisors get the extra high cycle.
    half   = ({1'b0, div_d} + (W+1)'(1)) >> 1;
    clk_d  = (div_d != '0) && ({1'b0, cnt_d} < half);
    tick_d = (div_d != '0) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= W'(DEFAULT_DIV);
      pdiv_q <= '0;
      pend_q <= 1'b0;
      clk_q  <= (DEFAULT_DIV != 0);
      tick_q <= (DEFAULT_DIV != 0);
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers sharing one clock and sync pulse.
// Ports: CLK/rst_n, wr_en/wr_ch/wr_div, sync; clk_out, tick, pending.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int W           = W_DEFAULT,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ch_w(NCH)-1:0]  wr_ch,
  input  logic [W-1:0]          wr_div,
  input  logic                  sync,
  output logic [NCH-1:0]        clk_out,
  output logic [NCH-1:0]        tick,
  output logic [NCH-1:0]        pending
);

  localparam int CW = ch_w(NCH);

  logic           wr_ok;
  logic [NCH-1:0] wr_sel;

  // Out-of-range channel numbers select nothing.
  always_comb begin
    wr_ok  = wr_en && ({1'b0, wr_ch} < (CW+1)'(NCH));
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_ok && (wr_ch == CW'(i))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (CLK),
      .rst_n   (rst_n),
      .wr      (wr_sel[g]),
      .wr_div  (wr_div),
      .sync    (sync),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter W, default 8: divisor width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 4: divisor loaded into every channel at reset (0..2^W-1).
REQ-004 SHALL have port CLK  input  1  the single system clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  input  1  one-cycle divisor write strobe.
REQ-007 SHALL have port wr_ch  input  clog2(NCH) (min 1)  target channel of a write.
REQ-008 SHALL have port wr_div  input  W  new divisor; 0 = channel stopped.
REQ-009 SHALL have port sync  input  1  one-cycle pulse that phase-aligns all channels.
REQ-010 SHALL have port clk_out  output  NCH  divided clock per channel, driven directly by flops.
REQ-011 SHALL have port tick  output  NCH  one-cycle pulse at the start of each channel period, driven by flops.
REQ-012 SHALL have port pending  output  NCH  channel holds a written divisor not yet applied.

Function
REQ-013 SHALL keep per channel: counter cnt (W bits), active divisor div (W bits), pending divisor pdiv (W bits), pending flag.
REQ-014 SHALL, when div>=2, count cnt 0,1,...,div-1, then wrap to 0, one step per CLK.
REQ-015 SHALL drive clk_out high for ceil(div/2) cycles (cnt < ceil(div/2)) and low for floor(div/2) cycles; the odd-divisor extra cycle is on the high phase.
REQ-016 SHALL, when div==1, hold clk_out at 1 and assert tick every cycle.
REQ-017 SHALL, when div==0, hold cnt at 0, clk_out at 0, and tick at 0.
REQ-018 SHALL assert tick for exactly one cycle whenever cnt==0 and div!=0.
REQ-019 SHALL register clk_out and tick from next-state values so that both are glitch-free and change only on the CLK posedge.
REQ-020 SHALL, on wr_en with wr_ch<NCH, store wr_div into pdiv and set pending on the next edge.
REQ-021 SHALL let a second write to a still-pending channel overwrite pdiv, keeping only the last value.
REQ-022 SHALL ignore writes with wr_ch>=NCH and leave all state unchanged.
REQ-023 SHALL apply a pending divisor only at a period boundary: on the edge where cnt==div-1 (or div<=1), load div<=pdiv, cnt<=0, and clear pending.
REQ-024 SHALL, for a channel with div==0, apply a pending divisor on the next edge and produce a tick on that first cycle.
REQ-025 SHALL, on sync, force cnt<=0 on all channels and apply every pending divisor immediately on the same edge.
REQ-026 SHALL, when sync and wr_en coincide, apply the written value to wr_ch immediately; that channel's pending SHALL remain 0.
REQ-027 SHALL, when a write arrives on the same edge as a boundary of its channel, apply the new value at that boundary; pending SHALL not be set.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously set cnt=0, div=DEFAULT_DIV, pdiv=0, pending=0 on all channels.
REQ-029 SHALL, while rst_n=0, set clk_out=1 and tick=1 when DEFAULT_DIV!=0, else clk_out=0 and tick=0.
REQ-030 SHALL, after reset deassertion mid-operation, leave no partial period and no stale pending state; the first edge advances cnt to 1.

Structure
REQ-031 SHALL place the W default, NCH maximum, and channel-index width function in the shared package clk_div_pkg.
REQ-032 SHALL implement one channel as sub-module clk_div_chan, instantiated NCH times; write decode and sync fan-out stay in the top level.

Verification
REQ-033 SHALL verify reset with DEFAULT_DIV=4: release rst_n -> clk_out on every channel = 1,1,0,0 repeating; tick on cycles 0, 4, 8.
REQ-034 SHALL verify odd divisor: write ch1 div=5 -> after the current period ends, clk_out1 = 1,1,1,0,0 and pending1 is high until the boundary.
REQ-035 SHALL verify overwrite: write ch0 div=6 then div=3 within one period -> only div=3 is applied at the boundary; div=6 never appears.
REQ-036 SHALL verify stop/start: write ch2 div=0 -> clk_out2 = 0 from the boundary on; then write div=2 -> tick on the next cycle and clk_out2 = 1,0.
REQ-037 SHALL verify sync: channels with divisors 3, 4 and 7 run free, then sync is pulsed -> all channels tick on the same cycle after the pulse, and all pending flags clear.
REQ-038 SHALL verify asynchronous reset mid-period: drop rst_n between CLK edges at cnt=2 -> outputs take reset values immediately, without waiting for an edge.
